// File: rtl/data_sram_slave.sv
// Data-SRAM responder: in-order request queue, latency counter, byte-strobe word store.
// Define DATA_SRAM_RAND_DELAY_EN for LFSR-driven back-pressure and extra latency.
module data_sram_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int FIXED_LAT  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIXED_LAT + 4);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] idx;
    logic [3:0]            wstrb;
    logic [31:0]           wdata;
  } ent_t;

  ent_t        fifo_q [FIFO_DEPTH];
  ent_t        head;
  ent_t        new_ent;
  logic [PW:0] wp_q;
  logic [PW:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_load;
  logic        ready_q;
  logic        empty;
  logic        full;
  logic        one_left;
  logic        push;
  logic        pop;
  logic        head_load;
  logic        gate;
  logic        unused;
  logic [31:0] mem [2**ADDR_WIDTH];

`ifdef DATA_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0],
                 lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign gate     = lfsr_q[0];
  assign cnt_load = CW'(FIXED_LAT - 1) + CW'(lfsr_q[2:1]);
`else
  assign gate     = 1'b1;
  assign cnt_load = CW'(FIXED_LAT - 1);
`endif

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[PW] != rp_q[PW]) &&
                 (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign one_left = ((wp_q - rp_q) == (PW+1)'(1));
  assign head  = fifo_q[rp_q[PW-1:0]];

  // Outputs are forced low while reset is held, not just after it.
  assign addr_ok = resetn & ready_q & ~full & gate;
  assign data_ok = resetn & ~empty & (cnt_q == '0);
  assign rdata   = (data_ok & ~head.wr) ? mem[head.idx] : 32'h0;

  assign push = req & addr_ok;
  assign pop  = data_ok;
  assign head_load = (push & empty) | (pop & (~one_left | push));

  assign unused = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

  always_comb begin
    new_ent       = '0;
    new_ent.wr    = wr;
    new_ent.idx   = addr[ADDR_WIDTH+1:2];
    new_ent.wstrb = wstrb;
    new_ent.wdata = wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (head_load) begin
        cnt_q <= cnt_load;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q[PW-1:0]] <= new_ent;
  end

  always_ff @(posedge clk) begin
    if (pop & head.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (head.wstrb[i]) mem[head.idx][8*i +: 8] <= head.wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: two instances (latency 1 and 3) checked
// each cycle against a queue-based reference model.
module tb_data_sram_slave;

  typedef struct {
    bit          wr;
    int unsigned idx;
    bit [3:0]    st;
    bit [31:0]   wd;
  } ent_t;

  logic        clk;
  logic        rstn   [2];
  logic        req    [2];
  logic        wr     [2];
  logic [1:0]  size   [2];
  logic [31:0] addr   [2];
  logic [3:0]  wstrb  [2];
  logic [31:0] wdata  [2];
  logic        addr_ok[2];
  logic        data_ok[2];
  logic [31:0] rdata  [2];

  ent_t        mq [2][$];
  int          acc_cyc [2][$];
  int          dok_cyc [2][$];
  bit [31:0]   mm [2][65536];
  int          up  [2];
  int          due [2];
  bit          acc [2];
  bit          pop [2];
  int          n_dok [2];
  logic [31:0] last_rd [2];
  int          cyc;
  int          n_chk;
  int          n_fail;

  data_sram_slave #(.ADDR_WIDTH(16), .FIFO_DEPTH(4), .FIXED_LAT(1)) u_lat1 (
    .clk(clk), .resetn(rstn[0]), .req(req[0]), .wr(wr[0]),
    .size(size[0]), .addr(addr[0]), .wstrb(wstrb[0]), .wdata(wdata[0]),
    .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0])
  );

  data_sram_slave #(.ADDR_WIDTH(16), .FIFO_DEPTH(4), .FIXED_LAT(3)) u_lat3 (
    .clk(clk), .resetn(rstn[1]), .req(req[1]), .wr(wr[1]),
    .size(size[1]), .addr(addr[1]), .wstrb(wstrb[1]), .wdata(wdata[1]),
    .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        e_ok;
    logic        e_dok;
    logic [31:0] e_rd;
    ent_t        h;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e_ok = rstn[i] && up[i] >= 1 && mq[i].size() < 4;
`ifdef DATA_SRAM_RAND_DELAY_EN
      e_dok = data_ok[i];
      chk("orphan_data_ok", 32'(data_ok[i] && mq[i].size() == 0), 32'h0);
      if (!e_ok) chk("addr_ok_blocked", 32'(addr_ok[i]), 32'h0);
      acc[i] = req[i] && addr_ok[i];
`else
      e_dok = rstn[i] && mq[i].size() > 0 && cyc >= due[i];
      chk("addr_ok", 32'(addr_ok[i]), 32'(e_ok));
      chk("data_ok", 32'(data_ok[i]), 32'(e_dok));
      acc[i] = req[i] && e_ok;
`endif
      pop[i] = e_dok;
      if (e_dok && mq[i].size() > 0) begin
        h    = mq[i][0];
        e_rd = h.wr ? 32'h0 : mm[i][h.idx];
        chk("rdata", rdata[i], e_rd);
        if (!h.wr) last_rd[i] = rdata[i];
        dok_cyc[i].push_back(cyc);
        n_dok[i]++;
      end else if (!rstn[i]) begin
        chk("rdata_reset", rdata[i], 32'h0);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rstn[i]) begin
        mq[i].delete();
        up[i] = 0;
      end else begin
        if (up[i] < 2) up[i]++;
        if (pop[i] && mq[i].size() > 0) begin
          h = mq[i].pop_front();
          if (h.wr) begin
            for (int b = 0; b < 4; b++) begin
              if (h.st[b]) mm[i][h.idx][8*b +: 8] = h.wd[8*b +: 8];
            end
          end
          if (mq[i].size() > 0) due[i] = cyc + lat(i);
        end
        if (acc[i]) begin
          h.wr  = wr[i];
          h.idx = (addr[i] >> 2) & 32'hFFFF;
          h.st  = wstrb[i];
          h.wd  = wdata[i];
          if (mq[i].size() == 0) due[i] = cyc + lat(i);
          mq[i].push_back(h);
          acc_cyc[i].push_back(cyc);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic issue(int i, bit w, logic [31:0] a,
                       logic [3:0] s, logic [31:0] d);
    bit ok;
    ok       = 1'b0;
    req[i]   = 1'b1;
    wr[i]    = w;
    size[i]  = 2'd2;
    addr[i]  = a;
    wstrb[i] = s;
    wdata[i] = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      tick();
      ok = acc[i];
    end
    if (!ok) chk("accept_timeout", 32'(ok), 32'h1);
    req[i] = 1'b0;
  endtask

  task automatic drain(int i);
    for (int k = 0; k < 300 && mq[i].size() > 0; k++) tick();
    chk("drain", mq[i].size(), 32'h0);
  endtask

  task automatic clear_log(int i);
    acc_cyc[i].delete();
    dok_cyc[i].delete();
  endtask

  initial begin
    int          n_rand;
    int          base;
    logic [31:0] a;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0;
      addr[i] = '0; wstrb[i] = '0; wdata[i] = '0;
      up[i] = 0; due[i] = 0; n_dok[i] = 0; last_rd[i] = '0;
    end
    repeat (3) tick();
    chk("reset_addr_ok", 32'(addr_ok[0]), 32'h0);
    chk("reset_data_ok", 32'(data_ok[1]), 32'h0);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    tick();

    // Full-word store then load, latency 1
    clear_log(0);
    issue(0, 1, 32'h1000, 4'hF, 32'h12345678);
    issue(0, 0, 32'h1000, 4'h0, 32'h0);
    drain(0);
    chk("word_load", last_rd[0], 32'h12345678);
`ifndef DATA_SRAM_RAND_DELAY_EN
    chk("store_lat", dok_cyc[0][0] - acc_cyc[0][0], 32'd1);
    chk("load_lat", dok_cyc[0][1] - acc_cyc[0][0], 32'd2);
`endif

    issue(0, 1, 32'h1001, 4'b0010, 32'h0000AB00);
    issue(0, 0, 32'h1000, 4'h0, 32'h0);
    drain(0);
    chk("strobe_lane1", last_rd[0], 32'h1234AB78);

    issue(0, 1, 32'h1000, 4'h0, 32'hFFFFFFFF);
    issue(0, 0, 32'h1002, 4'h0, 32'h0);
    drain(0);
    chk("strobe_zero", last_rd[0], 32'h1234AB78);

    issue(0, 1, 32'h0004_0000, 4'hF, 32'hDEADBEEF);
    issue(0, 0, 32'h0, 4'h0, 32'h0);
    drain(0);
    chk("alias", last_rd[0], 32'hDEADBEEF);

    // Latency 3: fill the queue with loads while req stays high
    for (int k = 0; k < 5; k++) begin
      issue(1, 1, 32'h100 + 4*k, 4'hF, 32'hA0A0_0000 + k);
    end
    drain(1);
    clear_log(1);
    for (int k = 0; k < 5; k++) issue(1, 0, 32'h100 + 4*k, 4'h0, 32'h0);
    drain(1);
    chk("lat3_last_data", last_rd[1], 32'hA0A0_0004);
`ifndef DATA_SRAM_RAND_DELAY_EN
    chk("lat3_first", dok_cyc[1][0] - acc_cyc[1][0], 32'd3);
    for (int k = 1; k < 4; k++) begin
      chk("lat3_accept_gap", acc_cyc[1][k] - acc_cyc[1][k-1], 32'd1);
    end
    for (int k = 1; k < 5; k++) begin
      chk("lat3_dok_gap", dok_cyc[1][k] - dok_cyc[1][k-1], 32'd3);
    end
`endif

    // Reset with three loads in flight
    for (int k = 0; k < 3; k++) issue(1, 0, 32'h104 + 4*k, 4'h0, 32'h0);
    rstn[1] = 1'b0;
    base = n_dok[1];
    tick();
    rstn[1] = 1'b1;
    repeat (10) tick();
    chk("no_dok_after_reset", n_dok[1] - base, 32'd0);
    chk("addr_ok_after_reset", 32'(addr_ok[1]) | 32'(mq[1].size()), 32'h1);
    issue(1, 0, 32'h108, 4'h0, 32'h0);
    drain(1);
    chk("retained", last_rd[1], 32'hA0A0_0002);

    // Random traffic over a 256-word window with upper-bit aliasing
`ifdef DATA_SRAM_RAND_DELAY_EN
    n_rand = 2000;
`else
    n_rand = 300;
`endif
    for (int k = 0; k < 256; k++) begin
      issue(0, 1, 32'h2000 + 4*k, 4'hF, $urandom);
    end
    for (int k = 0; k < n_rand; k++) begin
      if ($urandom_range(0, 3) == 0) tick();
      a = 32'h2000 + 4 * $urandom_range(0, 255);
      a = a | ($urandom_range(0, 7) << 18) | $urandom_range(0, 3);
      issue(0, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
    end
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
